// File: rtl/bram_fifo_pkg.sv
// bram_fifo_pkg: shared constants, level type and helpers for bram_fifo_fwft.
package bram_fifo_pkg;
  localparam int PF_STAGES = 2;
  localparam int ST_OUT = 0;
  localparam int ST_BRAM = 1;
  localparam int MAX_LOG_DEPTH = 16;
  typedef logic [MAX_LOG_DEPTH:0] level_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic level_t lvl_next(input level_t l, input logic w, input logic r);
    return l + level_t'(w) - level_t'(r);
  endfunction
endpackage

// File: rtl/sdp_bram_param.sv
// sdp_bram_param: simple-dual-port BRAM with a registered read port.
module sdp_bram_param #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 512,
  parameter int LOG_DEPTH = 9
)(
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [LOG_DEPTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rd_en,
  input  logic [LOG_DEPTH-1:0] rd_addr,
  output logic [WIDTH-1:0]     rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/bram_fifo_fwft.sv
// bram_fifo_fwft: FWFT stream FIFO over a BRAM with level and almost flags.
// Define BRAM_FIFO_PEAK_EN to add the peak_level high-water mark and peak_clr.
module bram_fifo_fwft
  import bram_fifo_pkg::*;
#(
  parameter int WIDTH = 72,
  parameter int DEPTH = 512,
  parameter int LOG_DEPTH = clog2(DEPTH),
  parameter int AFULL_TH = 480,
  parameter int AEMPTY_TH = 16
)(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 flush,
  input  logic [WIDTH-1:0]     ss_data,
  input  logic                 ss_valid,
  output logic                 ss_ready,
  output logic [WIDTH-1:0]     ms_data,
  output logic                 ms_valid,
  input  logic                 ms_ready,
  output logic [LOG_DEPTH:0]   level,
  output logic                 almost_full,
  output logic                 almost_empty
`ifdef BRAM_FIFO_PEAK_EN
  ,
  input  logic                 peak_clr,
  output logic [LOG_DEPTH:0]   peak_level
`endif
);
  localparam int LW = LOG_DEPTH + 1;
  logic [LOG_DEPTH-1:0] wptr, rptr;
  logic [PF_STAGES-1:0] pf;
  logic [WIDTH-1:0] rd_data;
  logic [LOG_DEPTH:0] level_nx, mem_cnt;
  logic clr, wr, rd, out_ld, rd_iss;
  assign clr = !resetn || flush;
  assign ss_ready = resetn && !flush && !level[LOG_DEPTH];
  assign ms_valid = pf[ST_OUT];
  assign wr = ss_valid && ss_ready;
  assign rd = ms_valid && ms_ready;
  assign out_ld = pf[ST_BRAM] && (!pf[ST_OUT] || ms_ready);
  // words still sitting in the BRAM, i.e. committed but not yet fetched
  assign mem_cnt = level - LW'(pf[ST_OUT]) - LW'(pf[ST_BRAM]);
  assign rd_iss = (mem_cnt != '0) && (!pf[ST_BRAM] || out_ld);
  assign level_nx = LW'(lvl_next(level_t'(level), wr, rd));
  sdp_bram_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LOG_DEPTH(LOG_DEPTH)) u_bram (
    .clk(clk),
    .wr_en(wr),
    .wr_addr(wptr),
    .wr_data(ss_data),
    .rd_en(rd_iss),
    .rd_addr(rptr),
    .rd_data(rd_data)
  );
  always_ff @(posedge clk) begin
    if (clr) begin
      wptr <= '0;
      rptr <= '0;
      pf <= '0;
      level <= '0;
      almost_full <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (wr) wptr <= wptr + LOG_DEPTH'(1);
      if (rd_iss) rptr <= rptr + LOG_DEPTH'(1);
      pf[ST_BRAM] <= rd_iss ? 1'b1 : (out_ld ? 1'b0 : pf[ST_BRAM]);
      pf[ST_OUT] <= out_ld ? 1'b1 : (rd ? 1'b0 : pf[ST_OUT]);
      level <= level_nx;
      almost_full <= level_nx >= LW'(AFULL_TH);
      almost_empty <= level_nx <= LW'(AEMPTY_TH);
    end
  end
  always_ff @(posedge clk) begin
    if (out_ld) ms_data <= rd_data;
  end
`ifdef BRAM_FIFO_PEAK_EN
  always_ff @(posedge clk) begin
    if (clr) peak_level <= '0;
    else if (peak_clr || level_nx > peak_level) peak_level <= level_nx;
  end
`endif
endmodule
